// File: rtl/addsub_pkg.sv
// Shared types and constants for the bit-serial add/subtract unit.
// Holds the controller state encoding, the mode encodings and the default width.
package addsub_pkg;

  localparam int WIDTH_DEFAULT = 8;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

endpackage

// File: rtl/full_adder_1bit.sv
// One-bit full adder used as the single serial bit slice of the add/subtract unit.
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/addsub_serial_unit.sv
// Bit-serial add/subtract unit: accepts an operand pair, resolves one bit per clock
// LSB-first through a single full-adder slice, then holds result and flags until consumed.
module addsub_serial_unit
  import addsub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             fa_s, fa_cout;

  full_adder_1bit u_slice (
    .a    (a_q[cnt_q]),
    .b    (b_q[cnt_q]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  // Subtraction is a + ~b + 1: B is inverted at capture and the mode bit seeds the carry.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          a_d     = a;
          b_d     = (cin == MODE_ADD) ? b : ~b;
          carry_d = (cin == MODE_SUB);
          cnt_d   = '0;
          res_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        res_d[cnt_q] = fa_s;
        carry_d      = fa_cout;
        cnt_d        = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          s_d     = res_d;
          cout_d  = fa_cout;
          ovf_d   = carry_q ^ fa_cout;
          zero_d  = (res_d == '0);
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == DONE);
  assign s         = s_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_addsub_serial_unit.sv
// Scoreboard bench for addsub_serial_unit: expected results are queued at request time
// and compared when the unit presents its response.
module tb_addsub_serial_unit;

  typedef struct packed {
    logic [7:0] s;
    logic       cout;
    logic       ovf;
    logic       zero;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] s;
  logic       cout;
  logic       overflow;
  logic       zero;

  int   checks;
  int   failures;
  int   cycle;
  exp_t sb[$];

  addsub_serial_unit #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .s         (s),
    .cout      (cout),
    .overflow  (overflow),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Reference result from plain 9-bit arithmetic and sign-bit overflow rules.
  function automatic exp_t model(input logic [7:0] av, input logic [7:0] bv, input logic sub);
    exp_t       e;
    logic [8:0] sum9;
    if (sub) sum9 = {1'b0, av} - {1'b0, bv} + 9'h100;
    else     sum9 = {1'b0, av} + {1'b0, bv};
    e.s    = sum9[7:0];
    e.cout = sum9[8];
    if (sub) e.ovf = (av[7] != bv[7]) && (e.s[7] != av[7]);
    else     e.ovf = (av[7] == bv[7]) && (e.s[7] != av[7]);
    e.zero = (e.s == 8'd0);
    return e;
  endfunction

  task automatic compareResponse(input exp_t e);
    checkOutput("s", s, e.s);
    checkOutput("cout", cout, e.cout);
    checkOutput("overflow", overflow, e.ovf);
    checkOutput("zero", zero, e.zero);
  endtask

  // One full transaction; hold = cycles of withheld rsp_ready once the result appears.
  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic sub, input int hold);
    exp_t e;
    int   lat;
    sb.push_back(model(av, bv, sub));
    @(negedge clk);
    checkOutput("req_ready_idle", req_ready, 1);
    a = av; b = bv; cin = sub; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); cin = ~sub;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("latency", lat, 8);
    e = sb.pop_front();
    if (rsp_valid) begin
      compareResponse(e);
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        checkOutput("hold_rsp_valid", rsp_valid, 1);
        checkOutput("hold_req_ready", req_ready, 0);
        checkOutput("hold_s", s, e.s);
        checkOutput("hold_flags", {cout, overflow, zero}, {e.cout, e.ovf, e.zero});
      end
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      checkOutput("rsp_valid_drop", rsp_valid, 0);
      checkOutput("req_ready_back", req_ready, 1);
      checkOutput("s_kept", s, e.s);
    end
  endtask

  initial begin
    exp_t e;
    int   lastRsp;
    int   seen;
    checks    = 0;
    failures  = 0;
    cycle     = 0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    a = 8'd0; b = 8'd0; cin = 1'b0;
    #12;
    checkOutput("rst_req_ready", req_ready, 1);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_s", s, 0);
    checkOutput("rst_flags", {cout, overflow, zero}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(8'd5,   8'd3,   1'b1, 0);
    applyStimulus(8'd3,   8'd5,   1'b1, 0);
    applyStimulus(8'd128, 8'd128, 1'b1, 0);
    applyStimulus(8'd127, 8'd1,   1'b0, 0);
    applyStimulus(8'd0,   8'd128, 1'b1, 0);
    applyStimulus(8'd255, 8'd1,   1'b0, 0);

    applyStimulus(8'd77,  8'd200, 1'b0, 5);
    applyStimulus(8'd10,  8'd4,   1'b1, 0);

    // Reset with bit 4 of 200-100 about to be processed.
    @(negedge clk);
    a = 8'd200; b = 8'd100; cin = 1'b1; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_rsp_valid", rsp_valid, 0);
    checkOutput("midrst_req_ready", req_ready, 1);
    checkOutput("midrst_s", s, 0);
    checkOutput("midrst_flags", {cout, overflow, zero}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    checkOutput("midrst_no_rsp", seen, 0);
    applyStimulus(8'd200, 8'd100, 1'b1, 0);

    for (int i = 0; i <= 128; i += 16)
      for (int j = 0; j <= 128; j += 16) begin
        applyStimulus(8'(i), 8'(j), 1'b0, 0);
        applyStimulus(8'(i), 8'(j), 1'b1, 0);
      end
    for (int k = 0; k < 20; k++)
      applyStimulus(8'($urandom), 8'($urandom), 1'($urandom), 0);

    // Streaming: both valid and ready held high gives one result every 10 cycles.
    @(negedge clk);
    a = 8'd50; b = 8'd20; cin = 1'b0; req_valid = 1'b1; rsp_ready = 1'b1;
    e = model(8'd50, 8'd20, 1'b0);
    seen = 0;
    lastRsp = -1;
    repeat (45) begin
      @(posedge clk); #1;
      if (rsp_valid) begin
        seen++;
        compareResponse(e);
        if (lastRsp >= 0) checkOutput("stream_interval", cycle - lastRsp, 10);
        lastRsp = cycle;
      end
    end
    checkOutput("stream_count", seen, 4);
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    repeat (12) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    failures++;
    $display("[TB] FAIL timeout observed=%0d expected=%0d", cycle, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] timeout");
  end

endmodule
